// File: rtl/clkdiv_sched_if.sv
// Ratio-change handshake between a configuration master and the clkdiv_sched scheduler.
interface clkdiv_sched_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clkdiv_sched.sv
// Programmable divide-by-N scheduler: ratio changes take effect only at a period wrap.
// Optional feature: define CLKDIV_STICKY_ERR_EN to make err sticky until the next legal ratio.
module clkdiv_sched #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  clkdiv_sched_if.slave    cfg,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             div_out_q, tick_q, busy_q, err_q, err_d;
  logic [CNT_W:0]   half_d;
  logic             acc, acc_legal, acc_illegal, wrap;

  assign cfg.cfg_ready = (state_q != PEND);
  assign acc           = cfg.cfg_valid && cfg.cfg_ready;
  assign acc_legal     = acc && (cfg.cfg_div >= CNT_W'(2));
  assign acc_illegal   = acc && !acc_legal;
  assign wrap          = (state_q != IDLE) && (cnt_q == div_q - CNT_W'(1));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (acc_legal) div_d = cfg.cfg_div;
        if (enable) state_d = RUN;
      end
      RUN, PEND: begin
        if (wrap) begin
          // A ratio accepted on the wrap cycle itself skips the pending register.
          cnt_d = '0;
          if (state_q == PEND)  div_d = pend_q;
          else if (acc_legal)   div_d = cfg.cfg_div;
          state_d = enable ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (acc_legal) begin
            pend_d  = cfg.cfg_div;
            state_d = PEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    half_d = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
  end

`ifdef CLKDIV_STICKY_ERR_EN
  assign err_d = acc_illegal ? 1'b1 : (acc_legal ? 1'b0 : err_q);
`else
  assign err_d = acc_illegal;
`endif

  // Outputs are registered from next-state values so they line up with cnt_q/state_q.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEF_DIV);
      pend_q    <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      div_out_q <= (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
      tick_q    <= (state_d != IDLE) && (cnt_d == div_d - CNT_W'(1));
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;
  assign cur_div = div_q;
  assign err     = err_q;

endmodule

// File: doc/clkdiv_sched.md
# clkdiv_sched

Programmable clock-divider scheduler that sequences the divide-by-N datapath from a single fast clock. Produces a divided output and a one-cycle period tick, and accepts ratio changes over a valid/ready handshake. Changes apply only at a period boundary, so the divided output never has a runt high or low phase. Downstream divide-by-2/4/6 stages and clock-enable consumers are driven from `div_out`/`tick`.

## Interface
Parameters:
- `CNT_W`, 8: width of the ratio and the internal counter; legal N = 2 .. 2^CNT_W-1.
- `DEF_DIV`, 2: ratio loaded into `cur_div` at reset; must be legal.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run request; level-sensitive.
- `cfg_valid` in 1: new ratio offered.
- `cfg_div` in CNT_W: requested ratio N.
- `cfg_ready` out 1: scheduler can accept a ratio.
- `div_out` out 1: divided output, registered.
- `tick` out 1: one-cycle pulse on the last cycle of each period.
- `busy` out 1: high in RUN or PEND.
- `cur_div` out CNT_W: ratio currently in effect.
- `err` out 1: illegal ratio flag.

## Operation
- States: IDLE, RUN, PEND.
  - IDLE: counter held at 0; `div_out`=0.
  - RUN: dividing, no pending ratio.
  - PEND: dividing, a new ratio is held for the next boundary.
- Counter `cnt` counts 0..N-1 and wraps; `div_out`=1 when `cnt` < ceil(N/2), else 0.
  - N=3 gives high 2, low 1.
  - N=6 gives high 3, low 3.
- `tick`=1 when `cnt`==N-1 in RUN/PEND. This cycle is the period boundary (wrap).
- Handshake: a transfer occurs on `cfg_valid`&&`cfg_ready`. `cfg_ready` = (state != PEND).
- Illegal ratio (`cfg_div` < 2):
  - The transfer completes but is discarded.
  - `cur_div` and the state are unchanged.
  - `err` is raised (see Configuration).
- Legal accept in IDLE: `cur_div` is updated in the next cycle.
- Legal accept in RUN, off the boundary: value goes to the pending register; state moves to PEND.
- Legal accept on the boundary cycle itself: value goes straight into `cur_div` at this wrap; state stays RUN.
- PEND, at the boundary: `cur_div` takes the pending value, `cnt` goes to 0, state returns to RUN.
- IDLE to RUN: when `enable`=1. The first cycle after the transition has `cnt`=0 and `div_out`=1.
- Stop, `enable`=0 in RUN/PEND:
  - The current period is finished, and any pending ratio is applied at that wrap.
  - Then the state goes to IDLE, `div_out`=0, and `busy` falls.
  - If `enable` returns to 1 before the wrap, the stop is cancelled and there is no gap.
- Reset mid-operation: immediate return to IDLE; the pending value is lost.

## Timing
- Reset values:
  - `div_out`=0, `tick`=0, `busy`=0, `err`=0.
  - `cfg_ready`=1, `cur_div`=DEF_DIV, `cnt`=0, state IDLE.
- All outputs are registered, except `cfg_ready` (decoded from the state register).
- `enable` rising at edge k: `div_out` is high from edge k+1.
- Ratio change latency: the new `cur_div` is visible in the cycle after the boundary. The worst case is N_old cycles after acceptance.
- Period is exactly N cycles, with exactly one `tick` per period.
- No wrap occurs mid-period on a ratio change.

## Configuration
- `CLKDIV_STICKY_ERR_EN`, defined:
  - `err` is sticky: set in the cycle after an illegal accept.
  - Cleared by the next legal accept or by reset.
  - If both happen in the same cycle, set wins.
- `CLKDIV_STICKY_ERR_EN`, undefined: `err` is a one-cycle pulse in the cycle after each illegal accept.

## Test plan
- Reset, then `enable`=1 with DEF_DIV=2 -> `div_out` toggles 1,0,1,0; `tick` on every second cycle; `busy`=1.
- In IDLE, accept N=3, then enable -> `div_out` pattern 1,1,0 repeating; `tick` on the third cycle; `cur_div`=3.
- Running N=6, accept N=4 at `cnt`=1:
  - `cfg_ready` low until the boundary.
  - One full 6-cycle period completes (high 3/low 3), then a 4-cycle pattern 1,1,0,0.
- Running N=5, accept N=2 exactly on the `tick` cycle -> the next period is already N=2; state never enters PEND.
- Accept `cfg_div`=1 while running N=4:
  - `cur_div` stays 4; `err` asserts.
  - Without the macro, `err` falls after 1 cycle.
  - With the macro, `err` stays high until a legal accept of N=3.
- Running N=4: drop `enable` at `cnt`=1 -> 2 more cycles, then IDLE with `div_out`=0. Assert `reset` mid-period in a second run -> all outputs at reset values on the next sample.
